ddr3_sample_reader: RTL and testbench

DDR3_SAMPLE_READER -- requirements
Module: ddr3_sample_reader

---
 rtl/sgm_ddr_pkg.sv | 22 ++
 rtl/sample_fifo.sv | 51 +++++
 rtl/ddr3_sample_reader.sv | 200 ++++++++++++++++++++
 tb/tb_ddr3_sample_reader.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgm_ddr_pkg.sv
// Shared definitions for the DDR3 sample reader: MIG command codes, the address
// step per 256-bit word, the playback state encoding and the read word type.
package sgm_ddr_pkg;

  localparam logic [2:0]  CMD_WRITE = 3'b000;
  localparam logic [2:0]  CMD_READ  = 3'b001;
  // One 256-bit word spans eight 32-bit MIG address units.
  localparam logic [28:0] ADDR_STEP = 29'd8;

  localparam int unsigned WORD_W = 256;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CALIB,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO of 256-bit read words with show-ahead head and occupancy count.
// The caller guarantees no write when full and no read when empty.
module sample_fifo
  import sgm_ddr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  word_t                    wr_data,
  input  logic                     rd_en,
  output word_t                    rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  // Storage array; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/ddr3_sample_reader.sv
// Streams audio samples out of DDR3 through the MIG user interface.
// Reads num_words 256-bit words starting at base_addr, buffers them in sample_fifo
// and emits one SAMPLE_W lane per sample_tick, lane 0 first.
// Build option: define SAMPLE_LOOP_EN to replay the buffer region indefinitely.
module ddr3_sample_reader
  import sgm_ddr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SAMPLE_W   = 16
) (
  input  logic                ui_clk,
  input  logic                sys_rst,
  input  logic                init_calib_complete,
  input  logic                start,
  input  logic [28:0]         base_addr,
  input  logic [15:0]         num_words,
  input  logic                app_rdy,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [28:0]         app_addr,
  input  logic [255:0]        app_rd_data,
  input  logic                app_rd_data_valid,
  input  logic                sample_tick,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int unsigned LANES = WORD_W / SAMPLE_W;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 2;

  state_e state_q, state_d;

  logic [28:0]   addr_q;
  logic [15:0]   num_q;
  logic [15:0]   cmd_cnt_q;
  logic [AW:0]   outst_q;
  logic [LW-1:0] lane_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic          sample_valid_q;
  logic          underrun_q;

  logic [AW:0]   fifo_count;
  word_t         fifo_head;
  logic [LANES-1:0][SAMPLE_W-1:0] head_lanes;

  logic             valid_start;
  logic             in_flight;
  logic             beat;
  logic [LVL_W-1:0] level;
  logic             accept;
  logic             last_cmd;
  logic             have_data;
  logic             last_lane;
  logic             pop;

  // Handshake and datapath qualifiers.
  always_comb begin
    valid_start = start && ((state_q == IDLE) || (state_q == DONE));
    in_flight   = (state_q == READ) || (state_q == DRAIN);
    // Beats outside an active playback belong to an abandoned one.
    beat        = app_rd_data_valid && in_flight;
    // Reserve FIFO space for every read in flight so no beat is ever dropped.
    level       = LVL_W'(outst_q) + LVL_W'(fifo_count);
    app_en      = (state_q == READ) && (level < LVL_W'(FIFO_DEPTH));
    accept      = app_en && app_rdy;
    last_cmd    = accept && (cmd_cnt_q == (num_q - 16'd1));
    have_data   = (fifo_count != '0);
    last_lane   = (lane_q == LW'(LANES - 1));
    pop         = sample_tick && have_data && last_lane;
  end

  // Playback sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (num_words != 16'd0) ? WAIT_CALIB : DONE;
      end
      WAIT_CALIB: begin
        if (init_calib_complete) state_d = READ;
      end
`ifdef SAMPLE_LOOP_EN
      READ:  state_d = READ;
`else
      READ: begin
        if (last_cmd) state_d = DRAIN;
      end
`endif
      DRAIN: begin
        if (!have_data && (outst_q == '0)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

`ifdef SAMPLE_LOOP_EN
  logic [28:0] base_q;

  // Start address kept for wrapping back at the end of each pass.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst)         base_q <= '0;
    else if (valid_start) base_q <= base_addr;
  end
`endif

  // Command address and accepted-command count.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      addr_q    <= '0;
      num_q     <= '0;
      cmd_cnt_q <= '0;
    end else if (valid_start) begin
      addr_q    <= base_addr;
      num_q     <= num_words;
      cmd_cnt_q <= '0;
    end else if (accept) begin
`ifdef SAMPLE_LOOP_EN
      if (last_cmd) begin
        addr_q    <= base_q;
        cmd_cnt_q <= '0;
      end else begin
        addr_q    <= addr_q + ADDR_STEP;
        cmd_cnt_q <= cmd_cnt_q + 16'd1;
      end
`else
      addr_q    <= addr_q + ADDR_STEP;
      cmd_cnt_q <= cmd_cnt_q + 16'd1;
`endif
    end
  end

  // Reads issued but not yet returned; accept and return in one cycle cancel.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      outst_q <= '0;
    end else begin
      case ({accept, beat})
        2'b10:   outst_q <= outst_q + (AW+1)'(1);
        2'b01:   outst_q <= outst_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Lane unpacking, sample output and sticky underrun.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      lane_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (sample_tick) begin
        if (have_data) begin
          sample_q       <= head_lanes[lane_q];
          sample_valid_q <= 1'b1;
          lane_q         <= last_lane ? '0 : lane_q + LW'(1);
        end else if (in_flight) begin
          sample_q   <= '0;
          underrun_q <= 1'b1;
        end
      end
      if (valid_start) underrun_q <= 1'b0;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ui_clk),
    .rst_n   (sys_rst),
    .wr_en   (beat),
    .wr_data (app_rd_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign head_lanes   = fifo_head;
  assign app_cmd      = CMD_READ;
  assign app_addr     = addr_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q == WAIT_CALIB) || in_flight;
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_ddr3_sample_reader.sv
// Self-checking bench for ddr3_sample_reader: a MIG read model with programmable
// latency and ready behaviour, a sample-tick generator, and a reference of the
// expected command addresses and lane-ordered sample stream.
`timescale 1ns/1ps
module tb_ddr3_sample_reader;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned LANES      = 256 / SAMPLE_W;

  logic                ui_clk = 1'b0;
  logic                sys_rst;
  logic                init_calib_complete;
  logic                start;
  logic [28:0]         base_addr;
  logic [15:0]         num_words;
  logic                app_rdy;
  logic                app_en;
  logic [2:0]          app_cmd;
  logic [28:0]         app_addr;
  logic [255:0]        app_rd_data;
  logic                app_rd_data_valid;
  logic                sample_tick;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                busy;
  logic                done;
  logic                underrun;

  ddr3_sample_reader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SAMPLE_W   (SAMPLE_W)
  ) dut (
    .ui_clk              (ui_clk),
    .sys_rst             (sys_rst),
    .init_calib_complete (init_calib_complete),
    .start               (start),
    .base_addr           (base_addr),
    .num_words           (num_words),
    .app_rdy             (app_rdy),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .sample_tick         (sample_tick),
    .sample              (sample),
    .sample_valid        (sample_valid),
    .busy                (busy),
    .done                (done),
    .underrun            (underrun)
  );

  always #5 ui_clk = ~ui_clk;

  typedef struct {
    logic [28:0] addr;
    int          due;
  } rd_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  rd_t                 rq[$];
  logic [28:0]         cmd_log[$];
  logic [SAMPLE_W-1:0] obs[$];

  int          lat        = 4;
  int          rdy_mode   = 0;   // 0: always ready, 1: random
  int          rdy_hold   = 0;
  int          stall_seen = 0;
  int          stall_bad  = 0;
  logic [28:0] stall_addr = '0;
  int          tick_mode  = 0;   // 0: none, 1: every cycle, 2: random
  bit          watch_zero = 1'b0;
  int          zero_viol  = 0;
  logic [15:0] seed       = 16'h5A3C;

  // Memory contents: every (address, lane) pair gets its own value.
  function automatic logic [SAMPLE_W-1:0] lane_val(input logic [28:0] a, input int l);
    logic [15:0] v;
    v = a[15:0] * 16'h9E37;
    v = v ^ {3'b000, a[28:16]} ^ seed ^ (16'(l) * 16'h0101);
    return v;
  endfunction

  function automatic logic [255:0] mem_word(input logic [28:0] a);
    logic [255:0] w;
    for (int l = 0; l < LANES; l++) w[l*SAMPLE_W +: SAMPLE_W] = lane_val(a, l);
    return w;
  endfunction

  // MIG model, tick generator and output monitor, all away from the rising edge.
  always @(negedge ui_clk) begin
    cyc++;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      app_rd_data       = mem_word(rq[0].addr);
      app_rd_data_valid = 1'b1;
      void'(rq.pop_front());
    end else begin
      app_rd_data_valid = 1'b0;
    end
    if (rdy_hold != 0 && app_en) begin
      app_rdy = 1'b0;
      rdy_hold--;
      stall_seen++;
      if (app_addr !== stall_addr) stall_bad++;
    end else if (rdy_mode == 1) begin
      app_rdy = 1'($urandom_range(0, 1));
    end else begin
      app_rdy = 1'b1;
    end
    if (app_en && app_rdy) begin
      rq.push_back('{addr: app_addr, due: cyc + lat});
      cmd_log.push_back(app_addr);
    end
    case (tick_mode)
      1:       sample_tick = 1'b1;
      2:       sample_tick = ($urandom_range(0, 2) == 0);
      default: sample_tick = 1'b0;
    endcase
    if (sample_valid) obs.push_back(sample);
    if (watch_zero && busy && underrun && !sample_valid && sample != '0) zero_viol++;
  end

  task automatic do_start(input logic [28:0] b, input logic [15:0] n);
    @(negedge ui_clk);
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    @(negedge ui_clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge ui_clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    obs.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    repeat (3) @(negedge ui_clk);
    n_vec += 8;
    if (app_en !== 1'b0)      begin n_bad++; $display("FAIL rst_app_en: got %b want 0", app_en); end
    if (app_cmd !== 3'b001)   begin n_bad++; $display("FAIL rst_app_cmd: got %b want 001", app_cmd); end
    if (app_addr !== 29'h0)   begin n_bad++; $display("FAIL rst_app_addr: got %h want 0", app_addr); end
    if (sample !== '0)        begin n_bad++; $display("FAIL rst_sample: got %h want 0", sample); end
    if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL rst_sample_valid: got %b want 0", sample_valid); end
    if (busy !== 1'b0)        begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0)        begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    if (underrun !== 1'b0)    begin n_bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    sys_rst = 1'b1;
    repeat (2) @(negedge ui_clk);
  endtask

  task automatic test_basic();
    bit to;
    clear_logs();
    lat = 6; rdy_mode = 0; tick_mode = 2;
    do_start(29'h100, 16'd3);
    wait_done(3000, to);
    n_vec += 4;
    if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", to); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b want 0", busy); end
    if (cmd_log.size() != 3) begin n_bad++; $display("FAIL basic_ncmd: got %0d want 3", cmd_log.size()); end
    if (obs.size() != 3 * LANES) begin n_bad++; $display("FAIL basic_nsamp: got %0d want %0d", obs.size(), 3 * LANES); end
    for (int k = 0; k < 3 && k < cmd_log.size(); k++) begin
      n_vec++;
      if (cmd_log[k] !== 29'h100 + 29'(8 * k)) begin
        n_bad++; $display("FAIL basic_addr[%0d]: got %h want %h", k, cmd_log[k], 29'h100 + 29'(8 * k));
      end
    end
    for (int i = 0; i < 3 * LANES && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== lane_val(29'h100 + 29'(8 * (i / LANES)), i % LANES)) begin
        n_bad++; $display("FAIL basic_sample[%0d]: got %h want %h", i, obs[i],
                          lane_val(29'h100 + 29'(8 * (i / LANES)), i % LANES));
      end
    end
  endtask

  task automatic test_underrun();
    bit to;
    clear_logs();
    lat = 8; tick_mode = 1; zero_viol = 0; watch_zero = 1'b1;
    do_start(29'h180, 16'd2);
    wait_done(3000, to);
    watch_zero = 1'b0; tick_mode = 0;
    n_vec += 4;
    if (to !== 1'b0) begin n_bad++; $display("FAIL und_timeout: got %b want 0", to); end
    if (underrun !== 1'b1) begin n_bad++; $display("FAIL und_flag: got %b want 1", underrun); end
    if (zero_viol != 0) begin n_bad++; $display("FAIL und_zero: got %0d nonzero empty ticks want 0", zero_viol); end
    if (obs.size() != 2 * LANES) begin n_bad++; $display("FAIL und_nsamp: got %0d want %0d", obs.size(), 2 * LANES); end
    for (int i = 0; i < 2 * LANES && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== lane_val(29'h180 + 29'(8 * (i / LANES)), i % LANES)) begin
        n_bad++; $display("FAIL und_sample[%0d]: got %h want %h", i, obs[i],
                          lane_val(29'h180 + 29'(8 * (i / LANES)), i % LANES));
      end
    end
  endtask

  task automatic test_calib_and_ignore();
    bit to;
    int en_bad;
    clear_logs();
    en_bad = 0;
    init_calib_complete = 1'b0; lat = 5; tick_mode = 1;
    do_start(29'h200, 16'd2);
    // A second request while busy must not disturb the running playback.
    base_addr = 29'h700; num_words = 16'd5; start = 1'b1;
    @(negedge ui_clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ui_clk);
      if (app_en !== 1'b0) en_bad++;
    end
    n_vec += 3;
    if (en_bad != 0) begin n_bad++; $display("FAIL calib_en: got %0d cycles with app_en want 0", en_bad); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL calib_busy: got %b want 1", busy); end
    if (underrun !== 1'b0) begin n_bad++; $display("FAIL calib_underrun: got %b want 0", underrun); end
    tick_mode = 2;
    init_calib_complete = 1'b1;
    wait_done(3000, to);
    n_vec += 3;
    if (to !== 1'b0) begin n_bad++; $display("FAIL calib_timeout: got %b want 0", to); end
    if (cmd_log.size() != 2) begin n_bad++; $display("FAIL calib_ncmd: got %0d want 2", cmd_log.size()); end
    if (obs.size() != 2 * LANES) begin n_bad++; $display("FAIL calib_nsamp: got %0d want %0d", obs.size(), 2 * LANES); end
    for (int k = 0; k < 2 && k < cmd_log.size(); k++) begin
      n_vec++;
      if (cmd_log[k] !== 29'h200 + 29'(8 * k)) begin
        n_bad++; $display("FAIL calib_addr[%0d]: got %h want %h", k, cmd_log[k], 29'h200 + 29'(8 * k));
      end
    end
  endtask

  task automatic test_stall();
    bit to;
    clear_logs();
    lat = 4; tick_mode = 2;
    stall_seen = 0; stall_bad = 0; stall_addr = 29'h100; rdy_hold = 5;
    do_start(29'h100, 16'd2);
    wait_done(3000, to);
    n_vec += 4;
    if (to !== 1'b0) begin n_bad++; $display("FAIL stall_timeout: got %b want 0", to); end
    if (stall_seen != 5) begin n_bad++; $display("FAIL stall_cycles: got %0d want 5", stall_seen); end
    if (stall_bad != 0) begin n_bad++; $display("FAIL stall_addr_hold: got %0d bad cycles want 0", stall_bad); end
    if (cmd_log.size() != 2) begin n_bad++; $display("FAIL stall_ncmd: got %0d want 2", cmd_log.size()); end
    for (int k = 0; k < 2 && k < cmd_log.size(); k++) begin
      n_vec++;
      if (cmd_log[k] !== 29'h100 + 29'(8 * k)) begin
        n_bad++; $display("FAIL stall_addr[%0d]: got %h want %h", k, cmd_log[k], 29'h100 + 29'(8 * k));
      end
    end
    for (int i = 0; i < 2 * LANES && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== lane_val(29'h100 + 29'(8 * (i / LANES)), i % LANES)) begin
        n_bad++; $display("FAIL stall_sample[%0d]: got %h want %h", i, obs[i],
                          lane_val(29'h100 + 29'(8 * (i / LANES)), i % LANES));
      end
    end
  endtask

  task automatic test_flow_control();
    bit to;
    clear_logs();
    lat = 20; tick_mode = 0;
    do_start(29'h400, 16'd8);
    repeat (60) @(negedge ui_clk);
    n_vec++;
    if (cmd_log.size() != FIFO_DEPTH) begin
      n_bad++; $display("FAIL flow_limit: got %0d cmds want %0d", cmd_log.size(), FIFO_DEPTH);
    end
    tick_mode = 2;
    wait_done(6000, to);
    n_vec += 3;
    if (to !== 1'b0) begin n_bad++; $display("FAIL flow_timeout: got %b want 0", to); end
    if (cmd_log.size() != 8) begin n_bad++; $display("FAIL flow_ncmd: got %0d want 8", cmd_log.size()); end
    if (obs.size() != 8 * LANES) begin n_bad++; $display("FAIL flow_nsamp: got %0d want %0d", obs.size(), 8 * LANES); end
    for (int i = 0; i < 8 * LANES && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== lane_val(29'h400 + 29'(8 * (i / LANES)), i % LANES)) begin
        n_bad++; $display("FAIL flow_sample[%0d]: got %h want %h", i, obs[i],
                          lane_val(29'h400 + 29'(8 * (i / LANES)), i % LANES));
      end
    end
  endtask

  task automatic test_zero_words();
    clear_logs();
    tick_mode = 0;
    do_start(29'h500, 16'd0);
    repeat (4) @(negedge ui_clk);
    n_vec += 3;
    if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy); end
    if (cmd_log.size() != 0) begin n_bad++; $display("FAIL zero_ncmd: got %0d want 0", cmd_log.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit reached;
    clear_logs();
    lat = 15; tick_mode = 0; reached = 1'b0;
    do_start(29'h600, 16'd2);
    for (int i = 0; i < 60; i++) begin
      @(negedge ui_clk);
      if (cmd_log.size() >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge ui_clk);
    n_vec += 2;
    if (reached !== 1'b1) begin n_bad++; $display("FAIL mid_cmds: got %0d cmds want 2", cmd_log.size()); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    sys_rst = 1'b0;
    @(negedge ui_clk);
    n_vec += 6;
    if (app_en !== 1'b0)       begin n_bad++; $display("FAIL mid_app_en: got %b want 0", app_en); end
    if (app_addr !== 29'h0)    begin n_bad++; $display("FAIL mid_app_addr: got %h want 0", app_addr); end
    if (busy !== 1'b0)         begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (done !== 1'b0)         begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL mid_sample_valid: got %b want 0", sample_valid); end
    if (sample !== '0)         begin n_bad++; $display("FAIL mid_sample: got %h want 0", sample); end
    @(negedge ui_clk);
    sys_rst = 1'b1;
    obs.delete();
    tick_mode = 2;
    repeat (25) @(negedge ui_clk);
    n_vec += 2;
    if (obs.size() != 0) begin n_bad++; $display("FAIL mid_discard: got %0d samples want 0", obs.size()); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got busy %b want 0", busy); end
    clear_logs();
    lat = 5;
    do_start(29'h640, 16'd2);
    wait_done(3000, to);
    n_vec += 3;
    if (to !== 1'b0) begin n_bad++; $display("FAIL mid_restart_timeout: got %b want 0", to); end
    if (cmd_log.size() != 2) begin n_bad++; $display("FAIL mid_restart_ncmd: got %0d want 2", cmd_log.size()); end
    if (obs.size() != 2 * LANES) begin n_bad++; $display("FAIL mid_restart_nsamp: got %0d want %0d", obs.size(), 2 * LANES); end
    for (int i = 0; i < 2 * LANES && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== lane_val(29'h640 + 29'(8 * (i / LANES)), i % LANES)) begin
        n_bad++; $display("FAIL mid_restart_sample[%0d]: got %h want %h", i, obs[i],
                          lane_val(29'h640 + 29'(8 * (i / LANES)), i % LANES));
      end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [28:0] b;
    int n;
    rdy_mode = 1; tick_mode = 2;
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      seed = 16'($urandom);
      // First pass straddles the top of the 29-bit address space.
      b    = (it == 0) ? 29'h1FFF_FFF0 : 29'($urandom);
      n    = (it == 0) ? 4 : int'($urandom_range(1, 5));
      lat  = int'($urandom_range(1, 12));
      do_start(b, 16'(n));
      wait_done(8000, to);
      n_vec += 3;
      if (to !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_timeout: got %b want 0", it, to); end
      if (cmd_log.size() != n) begin n_bad++; $display("FAIL rnd%0d_ncmd: got %0d want %0d", it, cmd_log.size(), n); end
      if (obs.size() != n * LANES) begin n_bad++; $display("FAIL rnd%0d_nsamp: got %0d want %0d", it, obs.size(), n * LANES); end
      for (int k = 0; k < n && k < cmd_log.size(); k++) begin
        n_vec++;
        if (cmd_log[k] !== b + 29'(8 * k)) begin
          n_bad++; $display("FAIL rnd%0d_addr[%0d]: got %h want %h", it, k, cmd_log[k], b + 29'(8 * k));
        end
      end
      for (int i = 0; i < n * LANES && i < obs.size(); i++) begin
        n_vec++;
        if (obs[i] !== lane_val(b + 29'(8 * (i / LANES)), i % LANES)) begin
          n_bad++; $display("FAIL rnd%0d_sample[%0d]: got %h want %h", it, i, obs[i],
                            lane_val(b + 29'(8 * (i / LANES)), i % LANES));
        end
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_loop();
    bit reached;
    clear_logs();
    lat = 4; tick_mode = 2; reached = 1'b0;
    do_start(29'h40, 16'd2);
    for (int i = 0; i < 2000; i++) begin
      @(negedge ui_clk);
      if (cmd_log.size() >= 6) begin
        reached = 1'b1;
        break;
      end
    end
    n_vec += 3;
    if (reached !== 1'b1) begin n_bad++; $display("FAIL loop_progress: got %0d cmds want 6", cmd_log.size()); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL loop_done: got %b want 0", done); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL loop_busy: got %b want 1", busy); end
    for (int k = 0; k < 6 && k < cmd_log.size(); k++) begin
      n_vec++;
      if (cmd_log[k] !== 29'h40 + 29'(8 * (k % 2))) begin
        n_bad++; $display("FAIL loop_addr[%0d]: got %h want %h", k, cmd_log[k], 29'h40 + 29'(8 * (k % 2)));
      end
    end
    tick_mode = 0;
    sys_rst = 1'b0;
    repeat (2) @(negedge ui_clk);
    sys_rst = 1'b1;
    repeat (30) @(negedge ui_clk);
  endtask

  initial begin
    sys_rst             = 1'b0;
    init_calib_complete = 1'b1;
    start               = 1'b0;
    base_addr           = '0;
    num_words           = '0;
    app_rdy             = 1'b1;
    app_rd_data         = '0;
    app_rd_data_valid   = 1'b0;
    sample_tick         = 1'b0;
    test_reset();
`ifdef SAMPLE_LOOP_EN
    test_loop();
`else
    test_basic();
    test_underrun();
    test_calib_and_ignore();
    test_stall();
    test_flow_control();
    test_zero_words();
    test_reset_mid();
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
